// File: rtl/dvp_rgb565_capture_pkg.sv
// Shared types and pixel helpers for the DVP RGB565 capture front end.
// TEST_PATTERN_EN adds the colour-bar helper used in place of camera data.
package dvp_capture_pkg;

  localparam int RGB444_W = 12;

  typedef enum logic [1:0] {
    S_SKIP,
    S_WAIT,
    S_ACTIVE
  } state_t;

  // Keep the top bits of each channel: {R[4:1], G[5:2], B[4:1]}.
  function automatic logic [RGB444_W-1:0] rgb565_to_rgb444(input logic [15:0] pix);
    return {pix[15:12], pix[10:7], pix[4:1]};
  endfunction

`ifdef TEST_PATTERN_EN
  function automatic logic [RGB444_W-1:0] bar_colour(input logic [2:0] bar);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction
`endif

endpackage

// File: rtl/dvp_rgb565_capture_if.sv
// Camera byte bus in, RGB444 pixel stream out; slave is the capture block,
// master is whatever drives the camera pins and consumes the stream.
interface dvp_rgb565_capture_if;
  import dvp_capture_pkg::*;

  logic                i_dvp_vsync;
  logic                i_dvp_href;
  logic [7:0]          i_dvp_data;
  logic                o_rgb565_vde;
  logic                o_rgb565_vsync;
  logic [RGB444_W-1:0] o_rgb565_data;
  logic                o_line_error;

  modport master (
    output i_dvp_vsync,
    output i_dvp_href,
    output i_dvp_data,
    input  o_rgb565_vde,
    input  o_rgb565_vsync,
    input  o_rgb565_data,
    input  o_line_error
  );

  modport slave (
    input  i_dvp_vsync,
    input  i_dvp_href,
    input  i_dvp_data,
    output o_rgb565_vde,
    output o_rgb565_vsync,
    output o_rgb565_data,
    output o_line_error
  );

endinterface

// File: rtl/dvp_rgb565_capture_byte_pair.sv
// Pairs camera bytes {R5,G[5:3]} then {G[2:0],B5} into one RGB565 pixel and
// flags lines that end on an unpaired byte.
module dvp_byte_pair (
  input  logic        i_camera_clk,
  input  logic        i_rstn,
  input  logic        enable,
  input  logic        href,
  input  logic        href_fall,
  input  logic        abort,
  input  logic [7:0]  data,
  output logic        pixel_valid,
  output logic [15:0] pixel,
  output logic        odd_error
);

  logic       phase;
  logic [7:0] byte_a;

  // Abort (vsync mid-line) and leaving the active state both drop any half pixel.
  always_ff @(posedge i_camera_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase       <= 1'b0;
      byte_a      <= 8'd0;
      pixel       <= 16'd0;
      pixel_valid <= 1'b0;
      odd_error   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      odd_error   <= 1'b0;
      if (!enable || abort) begin
        phase <= 1'b0;
      end else if (href) begin
        if (!phase) begin
          byte_a <= data;
          phase  <= 1'b1;
        end else begin
          pixel       <= {byte_a, data};
          pixel_valid <= 1'b1;
          phase       <= 1'b0;
        end
      end else if (href_fall) begin
        odd_error <= phase;
        phase     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dvp_rgb565_capture.sv
// DVP camera capture: frame skip after reset, RGB565 -> RGB444, crop to
// IMAGE_SIZE_H x IMAGE_SIZE_V. Define TEST_PATTERN_EN for colour bars.
module dvp_rgb565_capture
  import dvp_capture_pkg::*;
#(
  parameter logic [15:0] IMAGE_SIZE_H = 16'd512,
  parameter logic [15:0] IMAGE_SIZE_V = 16'd384,
  parameter logic [7:0]  FRAME_SKIP   = 8'd10
) (
  input logic                 i_camera_clk,
  input logic                 i_rstn,
  dvp_rgb565_capture_if.slave dvp
);

  logic                vsync_s1, href_s1, vsync_d, href_d;
  logic [7:0]          data_s1;
  logic                vsync_rise, vsync_fall, href_fall;
  state_t              state;
  logic [7:0]          skip_cnt;
  logic [11:0]         x_cnt, y_cnt;
  logic                in_crop, active, entering_active;
  logic                pixel_valid, odd_error;
  logic [15:0]         pixel;
  logic [RGB444_W-1:0] pixel_rgb;
  logic                vde_q, vsync_q, line_error_q;
  logic [RGB444_W-1:0] data_q;

  always_ff @(posedge i_camera_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vsync_s1 <= 1'b0;
      href_s1  <= 1'b0;
      data_s1  <= 8'd0;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      vsync_s1 <= dvp.i_dvp_vsync;
      href_s1  <= dvp.i_dvp_href;
      data_s1  <= dvp.i_dvp_data;
      vsync_d  <= vsync_s1;
      href_d   <= href_s1;
    end
  end

  assign vsync_rise      = vsync_s1 & ~vsync_d;
  assign vsync_fall      = ~vsync_s1 & vsync_d;
  assign href_fall       = ~href_s1 & href_d;
  assign active          = (state == S_ACTIVE);
  assign entering_active = (state == S_WAIT) && vsync_fall;

  // Frames are counted by vsync falls; the FRAME_SKIP-th fall arms S_WAIT.
  always_ff @(posedge i_camera_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= S_SKIP;
      skip_cnt <= 8'd0;
    end else begin
      case (state)
        S_SKIP: begin
          if (FRAME_SKIP == 8'd0) begin
            state <= S_WAIT;
          end else if (vsync_fall) begin
            if (skip_cnt + 8'd1 == FRAME_SKIP) state <= S_WAIT;
            skip_cnt <= skip_cnt + 8'd1;
          end
        end
        S_WAIT:   if (vsync_fall) state <= S_ACTIVE;
        S_ACTIVE: if (vsync_rise) state <= S_WAIT;
        default:  state <= S_SKIP;
      endcase
    end
  end

  dvp_byte_pair u_byte_pair (
    .i_camera_clk (i_camera_clk),
    .i_rstn       (i_rstn),
    .enable       (active),
    .href         (href_s1),
    .href_fall    (href_fall),
    .abort        (vsync_rise & href_s1),
    .data         (data_s1),
    .pixel_valid  (pixel_valid),
    .pixel        (pixel),
    .odd_error    (odd_error)
  );

`ifdef TEST_PATTERN_EN
  assign pixel_rgb = bar_colour(x_cnt[8:6]);
`else
  assign pixel_rgb = rgb565_to_rgb444(pixel);
`endif

  assign in_crop = ({4'd0, x_cnt} < IMAGE_SIZE_H) && ({4'd0, y_cnt} < IMAGE_SIZE_V);

  // The last pixel of a line and its href fall land together: crop uses the
  // old x/y, then the line clear wins. Counters saturate so huge lines never wrap back in.
  always_ff @(posedge i_camera_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_cnt        <= 12'd0;
      y_cnt        <= 12'd0;
      vde_q        <= 1'b0;
      vsync_q      <= 1'b0;
      data_q       <= '0;
      line_error_q <= 1'b0;
    end else begin
      vde_q   <= 1'b0;
      vsync_q <= active;
      if (entering_active) begin
        x_cnt <= 12'd0;
        y_cnt <= 12'd0;
      end else begin
        if (pixel_valid && (x_cnt != 12'hFFF)) x_cnt <= x_cnt + 12'd1;
        if (active && href_fall) begin
          x_cnt <= 12'd0;
          if (y_cnt != 12'hFFF) y_cnt <= y_cnt + 12'd1;
        end
      end
      if (pixel_valid && in_crop) begin
        vde_q  <= 1'b1;
        data_q <= pixel_rgb;
      end
      if (odd_error) line_error_q <= 1'b1;
    end
  end

  assign dvp.o_rgb565_vde   = vde_q;
  assign dvp.o_rgb565_vsync = vsync_q;
  assign dvp.o_rgb565_data  = data_q;
  assign dvp.o_line_error   = line_error_q;

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Randomised frames checked against a pixel-level reference model through a
// scoreboard queue; a negedge monitor pops one entry per output strobe.
module tb_dvp_rgb565_capture;

  localparam int H    = 512;
  localparam int V    = 384;
  localparam int SKIP = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  dvp_rgb565_capture_if cam_if ();

  dvp_rgb565_capture #(
    .IMAGE_SIZE_H (16'(H)),
    .IMAGE_SIZE_V (16'(V)),
    .FRAME_SKIP   (8'(SKIP))
  ) dut (
    .i_camera_clk (clk),
    .i_rstn       (rstn),
    .dvp          (cam_if)
  );

  typedef struct {
    logic [11:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        expQ[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          strobeCount = 0;
  int          fallCount = 0;
  int          lineIdx = 0;
  bit          frameActive = 1'b0;
  logic [7:0]  fixedBytes [0:5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    cam_if.i_dvp_vsync = vs;
    cam_if.i_dvp_href  = hr;
    cam_if.i_dvp_data  = d;
  endtask

  // Reference RGB565 -> RGB444: halve red and blue, quarter green, repack.
  function automatic logic [11:0] refRgb444(input logic [7:0] a, input logic [7:0] b);
    int pix, r, g, bl;
    pix = int'(a) * 256 + int'(b);
    r   = pix / 2048;
    g   = (pix / 32) % 64;
    bl  = pix % 32;
    return 12'((r / 2) * 256 + (g / 4) * 16 + (bl / 2));
  endfunction

  // Called right after byte B is driven: the strobe is due three posedges later.
  task automatic pushPixel(input logic [7:0] a, input logic [7:0] b, input int pixIdx);
    exp_t e;
    if (frameActive && lineIdx < V && pixIdx < H) begin
      e.data = refRgb444(a, b);
      e.cyc  = cyc + 3;
      expQ.push_back(e);
    end
  endtask

  task automatic frameStart();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    fallCount++;
    frameActive = (fallCount > SKIP);
    lineIdx = 0;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("frame_vsync_out", 32'(cam_if.o_rgb565_vsync), 32'(frameActive));
  endtask

  task automatic sendLine(input int nBytes, input bit useFixed);
    logic [7:0] b, prev;
    prev = 8'd0;
    for (int i = 0; i < nBytes; i++) begin
      b = useFixed ? fixedBytes[i] : 8'($urandom);
      applyStimulus(1'b0, 1'b1, b);
      if (i % 2 == 1) pushPixel(prev, b, i / 2);
      prev = b;
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
    lineIdx++;
  endtask

  // Monitor: every strobe must match the oldest expected pixel in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && cam_if.o_rgb565_vde) begin
      strobeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pixel_data", 32'(cam_if.o_rgb565_data), 32'(e.data));
        checkOutput("strobe_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    logic [7:0] a, b;
    int w;

    cam_if.i_dvp_vsync = 1'b0;
    cam_if.i_dvp_href  = 1'b0;
    cam_if.i_dvp_data  = 8'd0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vde", 32'(cam_if.o_rgb565_vde), 32'd0);
    checkOutput("reset_vsync", 32'(cam_if.o_rgb565_vsync), 32'd0);
    checkOutput("reset_data", 32'(cam_if.o_rgb565_data), 32'd0);
    checkOutput("reset_line_error", 32'(cam_if.o_line_error), 32'd0);
    rstn = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 8'd0);

    $display("[TB] frame skip: two skipped frames, then 4x8 active");
    s0 = strobeCount;
    for (int f = 0; f < 2; f++) begin
      frameStart();
      repeat (4) sendLine(16, 1'b0);
    end
    checkOutput("skip_frames_strobes", 32'(strobeCount - s0), 32'd0);
    s0 = strobeCount;
    frameStart();
    repeat (4) sendLine(16, 1'b0);
    checkOutput("frame3_strobes", 32'(strobeCount - s0), 32'd32);

    $display("[TB] primary colours");
    fixedBytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    frameStart();
    sendLine(6, 1'b1);
    checkOutput("held_data_blue", 32'(cam_if.o_rgb565_data), 32'h00F);
    checkOutput("vde_low_between", 32'(cam_if.o_rgb565_vde), 32'd0);

    $display("[TB] horizontal and vertical crop");
    frameStart();
    s0 = strobeCount;
    sendLine(1200, 1'b0);
    checkOutput("h_crop_strobes", 32'(strobeCount - s0), 32'd512);
    frameStart();
    s0 = strobeCount;
    repeat (400) sendLine(2, 1'b0);
    checkOutput("v_crop_strobes", 32'(strobeCount - s0), 32'd384);
    checkOutput("line_error_clean", 32'(cam_if.o_line_error), 32'd0);

    $display("[TB] vsync abort mid-line");
    frameStart();
    a = 8'($urandom);
    b = 8'($urandom);
    applyStimulus(1'b0, 1'b1, a);
    applyStimulus(1'b0, 1'b1, b);
    pushPixel(a, b, 0);
    applyStimulus(1'b0, 1'b1, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 8'($urandom));
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("abort_vsync_hold", 32'(cam_if.o_rgb565_vsync), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("abort_vsync_drop", 32'(cam_if.o_rgb565_vsync), 32'd0);
    checkOutput("abort_line_error", 32'(cam_if.o_line_error), 32'd0);

    $display("[TB] odd byte count");
    frameStart();
    s0 = strobeCount;
    sendLine(7, 1'b0);
    checkOutput("odd_line_strobes", 32'(strobeCount - s0), 32'd3);
    checkOutput("odd_line_error", 32'(cam_if.o_line_error), 32'd1);
    s0 = strobeCount;
    sendLine(8, 1'b0);
    checkOutput("after_odd_strobes", 32'(strobeCount - s0), 32'd4);

    $display("[TB] reset mid-line");
    frameStart();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      applyStimulus(1'b0, 1'b1, b);
      if (i % 2 == 1) pushPixel(a, b, i / 2);
      a = b;
    end
    @(posedge clk);
    #2;
    rstn = 1'b0;
    cam_if.i_dvp_vsync = 1'b0;
    cam_if.i_dvp_href  = 1'b0;
    cam_if.i_dvp_data  = 8'd0;
    expQ.delete();
    #1;
    checkOutput("midreset_vde", 32'(cam_if.o_rgb565_vde), 32'd0);
    checkOutput("midreset_vsync", 32'(cam_if.o_rgb565_vsync), 32'd0);
    checkOutput("midreset_data", 32'(cam_if.o_rgb565_data), 32'd0);
    checkOutput("midreset_line_error", 32'(cam_if.o_line_error), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    fallCount = 0;
    frameActive = 1'b0;
    s0 = strobeCount;
    for (int f = 0; f < 2; f++) begin
      frameStart();
      repeat (2) sendLine(8, 1'b0);
    end
    checkOutput("reskip_strobes", 32'(strobeCount - s0), 32'd0);
    s0 = strobeCount;
    frameStart();
    repeat (2) sendLine(8, 1'b0);
    checkOutput("post_reset_strobes", 32'(strobeCount - s0), 32'd8);

    repeat (3) applyStimulus(1'b1, 1'b0, 8'd0);
    w = 0;
    while (expQ.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
